// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared widths and burst FSM state encoding
package lenet_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 18;
    localparam int LEN_WIDTH_DEF  = 12;
    localparam int FIFO_DEPTH_DEF = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous first-word-fall-through FIFO
module sync_fifo #(
    parameter int  DATA_WIDTH = 32,
    parameter int  DEPTH      = 8,
    localparam int PW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [PW:0]           count
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;
    logic                  do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != (PW+1)'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Gating the head keeps out_data at zero whenever nothing is buffered.
    assign pop_data = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign full     = (count_q == (PW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/dram_rd_burst.sv
// rtl/dram_rd_burst.sv - credit-limited DRAM burst reader feeding a FWFT stream
module dram_rd_burst
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  dram_en_rd,
    output logic [ADDR_WIDTH-1:0] dram_addr_rd,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] dram_data_rd,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic [LEN_WIDTH-1:0]  received_q, received_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic                  en_rd_q, en_rd_d;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full, fifo_empty;
    logic                  accept_rsp, credit_ok;
    logic [CW:0]           in_flight;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        addr_d     = addr_q;
        issued_d   = issued_q;
        received_d = received_q;
        en_rd_d    = 1'b0;

        // Buffer slots already promised: words held plus words still in DRAM.
        in_flight  = {1'b0, fifo_count} + {1'b0, outstanding_q};
        credit_ok  = in_flight < (CW+1)'(FIFO_DEPTH);
        accept_rsp = dram_valid && (outstanding_q != '0) && (state_q != ST_IDLE);
        if (accept_rsp) begin
            received_d = received_q + LEN_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        // First request goes out straight from the accepting edge.
                        base_d     = base_addr;
                        len_d      = len;
                        addr_d     = base_addr;
                        en_rd_d    = 1'b1;
                        issued_d   = LEN_WIDTH'(1);
                        received_d = '0;
                        state_d    = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if ((issued_q != len_q) && credit_ok) begin
                    en_rd_d  = 1'b1;
                    addr_d   = base_q + ADDR_WIDTH'(issued_q);
                    issued_d = issued_q + LEN_WIDTH'(1);
                end
                if (issued_d == len_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((received_q == len_q) && fifo_empty) begin
                    state_d = ST_FIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        outstanding_d = outstanding_q + CW'(en_rd_d) - CW'(accept_rsp);
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            len_q         <= '0;
            addr_q        <= '0;
            issued_q      <= '0;
            received_q    <= '0;
            outstanding_q <= '0;
            en_rd_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            len_q         <= len_d;
            addr_q        <= addr_d;
            issued_q      <= issued_d;
            received_q    <= received_d;
            outstanding_q <= outstanding_d;
            en_rd_q       <= en_rd_d;
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srstn     (srstn),
        .push      (accept_rsp),
        .push_data (dram_data_rd),
        .pop       (out_valid && out_ready),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid    = !fifo_empty;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_FIN);
    assign dram_en_rd   = en_rd_q;
    assign dram_addr_rd = addr_q;

endmodule

// File: tb/tb_dram_rd_burst.sv
// tb/tb_dram_rd_burst.sv - randomized scoreboard bench for dram_rd_burst
module tb_dram_rd_burst;

    localparam int DW = 32;
    localparam int AW = 18;
    localparam int LW = 12;
    localparam int FD = 8;

    logic          clk = 1'b0;
    logic          srstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done, dram_en_rd;
    logic [AW-1:0] dram_addr_rd;
    logic          dram_valid = 1'b0;
    logic [DW-1:0] dram_data_rd = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;

    dram_rd_burst dut (
        .clk          (clk),
        .srstn        (srstn),
        .start        (start),
        .base_addr    (base_addr),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .dram_en_rd   (dram_en_rd),
        .dram_addr_rd (dram_addr_rd),
        .dram_valid   (dram_valid),
        .dram_data_rd (dram_data_rd),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            ret;
        logic [AW-1:0] a;
    } req_t;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    req_t          pend[$];
    int            last_ret = 0;
    int            lat_min = 1;
    int            lat_max = 1;
    int            ready_mode = 0;
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    int            req_cnt = 0;
    int            pop_cnt = 0;
    int            done_cnt = 0;
    int            max_inflight = 0;
    int            first_req_cyc = 0;
    int            last_req_cyc = 0;

    function automatic logic [DW-1:0] dram_word(input logic [AW-1:0] a);
        return {a[13:0], ~a} ^ 32'hA5C3_0F1E;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // DRAM responder, consumer and scoreboard monitor, all acting mid-cycle.
    always @(negedge clk) begin
        int lat;
        int r;
        if (pend.size() > 0 && pend[0].ret <= cyc) begin
            dram_valid   = 1'b1;
            dram_data_rd = dram_word(pend[0].a);
            void'(pend.pop_front());
        end else begin
            dram_valid   = 1'b0;
            dram_data_rd = $urandom;
        end
        if (dram_en_rd) begin
            lat = $urandom_range(lat_max, lat_min);
            r = cyc + lat;
            if (r <= last_ret) r = last_ret + 1;
            last_ret = r;
            pend.push_back('{ret: r, a: dram_addr_rd});
            req_cnt++;
            if (req_cnt == 1) first_req_cyc = cyc;
            last_req_cyc = cyc;
            if (exp_addr.size() == 0) check("unexpected_request", {46'd0, dram_addr_rd}, 64'hdead);
            else check("dram_addr", {46'd0, dram_addr_rd}, {46'd0, exp_addr.pop_front()});
        end
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (out_valid && out_ready) begin
            pop_cnt++;
            if (exp_data.size() == 0) check("unexpected_word", {32'd0, out_data}, 64'hdead);
            else check("out_data", {32'd0, out_data}, {32'd0, exp_data.pop_front()});
        end
        if (done) done_cnt++;
        if (req_cnt - pop_cnt > max_inflight) max_inflight = req_cnt - pop_cnt;
    end

    task automatic issue_start(input logic [AW-1:0] b, input logic [LW-1:0] l, input bit accepted);
        logic [AW-1:0] a;
        @(posedge clk); #2;
        start = 1'b1;
        base_addr = b;
        len = l;
        if (accepted) begin
            req_cnt = 0;
            pop_cnt = 0;
            max_inflight = 0;
            for (int i = 0; i < int'(l); i++) begin
                a = b + AW'(i);
                exp_addr.push_back(a);
                exp_data.push_back(dram_word(a));
            end
        end
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int done_before, input bit fin_start);
        int n;
        for (n = 0; n < 3000; n++) begin
            if (done) break;
            @(posedge clk); #2;
        end
        check({tag, "_done_seen"}, {63'd0, done}, 64'd1);
        check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd1);
        if (fin_start) begin
            start = 1'b1;
            base_addr = 18'h00500;
            len = 12'd2;
        end
        @(posedge clk); #2;
        start = 1'b0;
        check({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
        check({tag, "_done_after"}, {63'd0, done}, 64'd0);
        repeat (4) @(posedge clk);
        #2;
        check({tag, "_done_count"}, 64'(done_cnt - done_before), 64'd1);
        check({tag, "_addr_q_empty"}, 64'(exp_addr.size()), 64'd0);
        check({tag, "_data_q_empty"}, 64'(exp_data.size()), 64'd0);
        check({tag, "_invariant"}, 64'(max_inflight > FD), 64'd0);
    endtask

    initial begin
        int d0;
        int n;

        repeat (3) @(posedge clk);
        #2;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_en_rd", {63'd0, dram_en_rd}, 64'd0);
        check("reset_addr", {46'd0, dram_addr_rd}, 64'd0);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out_data", {32'd0, out_data}, 64'd0);
        srstn = 1'b1;

        // Basic burst, latency 1.
        lat_min = 1; lat_max = 1; ready_mode = 0;
        d0 = done_cnt;
        issue_start(18'h00100, 12'd4, 1'b1);
        check("t1_busy", {63'd0, busy}, 64'd1);
        wait_done("t1", d0, 1'b0);
        check("t1_req_count", 64'(req_cnt), 64'd4);
        check("t1_back_to_back", 64'(last_req_cyc - first_req_cyc), 64'd3);

        // Back-pressure: credits must stop issue at FIFO depth.
        lat_min = 3; lat_max = 3; ready_mode = 1;
        d0 = done_cnt;
        issue_start(18'h01000, 12'd20, 1'b1);
        repeat (30) @(posedge clk);
        #2;
        check("t2_req_during_stall", 64'(req_cnt), 64'd8);
        check("t2_pops_during_stall", 64'(pop_cnt), 64'd0);
        ready_mode = 0;
        wait_done("t2", d0, 1'b0);
        check("t2_req_count", 64'(req_cnt), 64'd20);

        // Address wrap.
        lat_min = 1; lat_max = 2; ready_mode = 2;
        d0 = done_cnt;
        issue_start(18'h3FFFE, 12'd4, 1'b1);
        wait_done("t3_wrap", d0, 1'b0);

        // Zero length: straight to FIN, no DRAM traffic.
        d0 = done_cnt;
        issue_start(18'h00200, 12'd0, 1'b1);
        check("t3_len0_done_now", {63'd0, done}, 64'd1);
        wait_done("t3_len0", d0, 1'b0);
        check("t3_len0_reqs", 64'(req_cnt), 64'd0);

        // Starts mid-burst and in the FIN cycle must be ignored.
        lat_min = 2; lat_max = 2; ready_mode = 2;
        d0 = done_cnt;
        issue_start(18'h00040, 12'd10, 1'b1);
        repeat (2) @(posedge clk);
        issue_start(18'h00500, 12'd2, 1'b0);
        wait_done("t4", d0, 1'b1);
        check("t4_req_count", 64'(req_cnt), 64'd10);

        // Reset after the 5th request aborts silently.
        lat_min = 4; lat_max = 4; ready_mode = 0;
        d0 = done_cnt;
        issue_start(18'h02000, 12'd16, 1'b1);
        for (n = 0; n < 200; n++) begin
            if (req_cnt >= 5) break;
            @(posedge clk); #1;
        end
        check("t5_reached_5_reqs", 64'(req_cnt >= 5), 64'd1);
        srstn = 1'b0;
        @(posedge clk); #2;
        exp_addr.delete();
        exp_data.delete();
        check("t5_rst_busy", {63'd0, busy}, 64'd0);
        check("t5_rst_en_rd", {63'd0, dram_en_rd}, 64'd0);
        check("t5_rst_addr", {46'd0, dram_addr_rd}, 64'd0);
        check("t5_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("t5_rst_out_data", {32'd0, out_data}, 64'd0);
        @(posedge clk); #2;
        srstn = 1'b1;
        for (n = 0; n < 100; n++) begin
            if (pend.size() == 0) break;
            @(posedge clk); #2;
        end
        repeat (3) @(posedge clk);
        #2;
        check("t5_no_done", 64'(done_cnt - d0), 64'd0);
        check("t5_idle", {63'd0, busy}, 64'd0);
        d0 = done_cnt;
        issue_start(18'h00007, 12'd3, 1'b1);
        wait_done("t5_after", d0, 1'b0);

        // Random latency and consumer stalls over a long burst.
        lat_min = 1; lat_max = 6; ready_mode = 2;
        d0 = done_cnt;
        issue_start(AW'($urandom), 12'd100, 1'b1);
        wait_done("t6", d0, 1'b0);
        check("t6_req_count", 64'(req_cnt), 64'd100);
        check("t6_pop_count", 64'(pop_cnt), 64'd100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
